// File: rtl/mse_cost.sv
// Squared-error cost over one vector pair, one element per clock through a shared squarer.
// Optional saturation of the square and the accumulator: define COST_SATURATE_EN.
module mse_cost #(
  parameter int size      = 3,
  parameter int data_size = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [size*data_size-1:0]   predict_value,
  input  logic [size*data_size-1:0]   z,
  output logic                        cost_valid,
  input  logic                        cost_ready,
  output logic [data_size-1:0]        cost,
  output logic                        overflow,
  output logic [1:0]                  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // The vector pair transfers only in IDLE; the cost transfers only in DONE, and the
  // producer side holds valid/data stable until the transfer.

  localparam int F  = data_size / 2;
  localparam int IW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [size*data_size-1:0]    p_q, z_q;
  logic [IW-1:0]                idx;
  logic [data_size-1:0]         acc, acc_next;
  logic                         ovf, ovf_step;
  logic signed [data_size-1:0]  p_el, z_el, d;
  logic signed [2*data_size-1:0] prd;
  logic [data_size-1:0]         sq;
  logic [data_size-1:0]         sum;
  logic                         last;

  assign p_el = p_q[int'(idx)*data_size +: data_size];
  assign z_el = z_q[int'(idx)*data_size +: data_size];
  assign last = (idx == IW'(size - 1));

  // Datapath for the element currently indexed by idx.
  always_comb begin
    d        = p_el - z_el;
    prd      = d * d;
    sq       = prd[data_size+F-1:F];
    sum      = acc + sq;
    acc_next = sum;
    ovf_step = 1'b0;
`ifdef COST_SATURATE_EN
    // prd is never negative, so any set bit at or above 2^(data_size-1+F) means too large.
    if (prd[2*data_size-1:data_size-1+F] != '0) begin
      sq       = {1'b0, {(data_size-1){1'b1}}};
      ovf_step = 1'b1;
    end
    sum      = acc + sq;
    acc_next = sum;
    // Both operands are non-negative and below 2^(data_size-1), so the sign bit flags overflow.
    if (sum[data_size-1]) begin
      acc_next = {1'b0, {(data_size-1){1'b1}}};
      ovf_step = 1'b1;
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (cost_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p_q   <= '0;
      z_q   <= '0;
      idx   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          p_q <= predict_value;
          z_q <= z;
          idx <= '0;
          acc <= '0;
          ovf <= 1'b0;
        end
        RUN: begin
          acc <= acc_next;
          ovf <= ovf | ovf_step;
          idx <= last ? '0 : idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign cost_valid = (state == DONE);
  assign cost       = acc;
  assign overflow   = ovf;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mse_cost.sv
// Self-checking bench for mse_cost (size=3, Q8.8) using an expected-result queue.
module tb_mse_cost;

  localparam int N = 3;
  localparam int W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   predict_value;
  logic [N*W-1:0]   z;
  logic             cost_valid;
  logic             cost_ready;
  logic [W-1:0]     cost;
  logic             overflow;
  logic [1:0]       state_dbg;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  mse_cost #(.size(N), .data_size(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .predict_value(predict_value), .z(z),
    .cost_valid(cost_valid), .cost_ready(cost_ready),
    .cost(cost), .overflow(overflow), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cost: real-valued squares in units of 2^-8, then Q8.8 truncation rules.
  function automatic void model(input logic [N*W-1:0] p, input logic [N*W-1:0] t,
                                output logic [W-1:0] c, output logic o);
    longint a;
    longint dv, sqv, pv;
    logic [W-1:0] dw;
    a = 0;
    o = 1'b0;
    for (int i = 0; i < N; i++) begin
      dw  = p[i*W +: W] - t[i*W +: W];
      dv  = longint'($signed(dw));
      pv  = dv * dv;
`ifdef COST_SATURATE_EN
      if (pv >= 64'sd8388608) begin
        sqv = 32767;
        o   = 1'b1;
      end else sqv = pv / 256;
      a = a + sqv;
      if (a > 32767) begin
        a = 32767;
        o = 1'b1;
      end
`else
      sqv = (pv / 256) % 65536;
      a   = (a + sqv) % 65536;
`endif
    end
    c = W'(a);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    else n_pass++;
  endtask

  // Present a vector pair for one accepting edge; leaves the bench at the negedge after accept.
  task automatic start_job(input logic [N*W-1:0] p, input logic [N*W-1:0] t);
    logic [W-1:0] c;
    logic o;
    @(negedge clk);
    check("in_ready_before_accept", W'(in_ready), W'(1));
    predict_value = p;
    z             = t;
    in_valid      = 1'b1;
    model(p, t, c, o);
    exp_q.push_back(c);
    exp_ovf_q.push_back(o);
    @(negedge clk);
    in_valid      = 1'b0;
    predict_value = $urandom();
    z             = $urandom();
  endtask

  // Wait for the result, hold it for 'hold' cycles, then handshake and compare.
  task automatic finish_job(input string name, input int hold);
    int n;
    logic [W-1:0] c;
    logic o;
    n = 0;
    while (!cost_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, W'(n), W'(3));
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_queue: got empty expected 1 entry", name);
      return;
    end
    c = exp_q.pop_front();
    o = exp_ovf_q.pop_front();
    check({name, "_cost"}, cost, c);
    check({name, "_overflow"}, W'(overflow), W'(o));
    for (int k = 0; k < hold; k++) begin
      in_valid = (k == 4);
      predict_value = $urandom();
      @(negedge clk);
      in_valid = 1'b0;
      check({name, "_hold_cost"}, cost, c);
      check({name, "_hold_ready"}, W'(in_ready), W'(0));
      check({name, "_hold_valid"}, W'(cost_valid), W'(1));
    end
    cost_ready = 1'b1;
    @(negedge clk);
    cost_ready = 1'b0;
    check({name, "_valid_drop"}, W'(cost_valid), W'(0));
    check({name, "_ready_back"}, W'(in_ready), W'(1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    cost_ready = 1'b0;
    predict_value = '0;
    z = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_cost_valid", W'(cost_valid), W'(0));
    check("reset_cost", cost, W'(0));
    check("reset_overflow", W'(overflow), W'(0));
    check("reset_state", W'(state_dbg), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", W'(in_ready), W'(1));
  endtask

  task automatic test_basic();
    start_job({16'h0300, 16'h0200, 16'h0100}, '0);
    check("t1_model", exp_q[0], 16'h0E00);
    finish_job("t1", 0);
    start_job({16'h0000, 16'hFF00, 16'h0080}, {16'h0000, 16'h0100, 16'h0100});
    check("t2_model", exp_q[0], 16'h0440);
    finish_job("t2", 0);
  endtask

  task automatic test_hold();
    start_job({16'h0100, 16'h0100, 16'h0100}, '0);
    finish_job("t3", 10);
    repeat (4) @(negedge clk);
    check("t3_pulse_ignored", W'(cost_valid), W'(0));
    check("t3_idle_ready", W'(in_ready), W'(1));
  endtask

  task automatic test_saturate();
    start_job({16'h0000, 16'h0000, 16'h6400}, '0);
`ifdef COST_SATURATE_EN
    check("t4_model", exp_q[0], 16'h7FFF);
`else
    check("t4_model", exp_q[0], 16'h1000);
`endif
    finish_job("t4", 0);
    // Several moderate squares whose sum passes the positive limit.
    start_job({16'h0B00, 16'h0B00, 16'h0B00}, '0);
    finish_job("t4_acc", 0);
  endtask

  task automatic test_reset_mid_job();
    start_job({16'h0300, 16'h0200, 16'h0100}, '0);
    rst_n = 1'b0;
    #1;
    check("t5_valid", W'(cost_valid), W'(0));
    check("t5_cost", cost, W'(0));
    check("t5_ready", W'(in_ready), W'(1));
    exp_q.delete();
    exp_ovf_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_job({16'h0300, 16'h0200, 16'h0100}, '0);
    finish_job("t5_rerun", 0);
  endtask

  task automatic test_back_to_back();
    start_job({16'h0300, 16'h0200, 16'h0100}, '0);
    finish_job("t6a", 0);
    start_job({16'h0000, 16'h0000, 16'h0080}, '0);
    check("t6b_model", exp_q[0], 16'h0040);
    finish_job("t6b", 0);
  endtask

  task automatic test_random();
    logic [N*W-1:0] p, t;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < N; i++) begin
        p[i*W +: W] = W'($urandom_range(0, 16'h0600)) - W'(16'h0300);
        t[i*W +: W] = W'($urandom_range(0, 16'h0600)) - W'(16'h0300);
      end
      start_job(p, t);
      finish_job("rand", $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_saturate();
    test_reset_mid_job();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
